// File: rtl/axis_ad5791_cfg_seq_if.sv
// Configuration port between the AD5791 power-up sequencer and the six-channel DAC driver.
// Carries the CFG word stream, the mode/axis/send controls and the driver's idle flag.
interface axis_ad5791_cfg_seq_if;
    // CFG stream has no tready: tvalid qualifies tdata and configuration_axis on every
    // cycle it is high. Frame handshake: configuration_send stays high until dac_ready
    // falls (frame accepted) or the sequencer gives up; dac_ready=1 means no frame in flight.
    logic [31:0] M_AXISCFG_tdata;
    logic        M_AXISCFG_tvalid;
    logic        configuration_mode;
    logic [2:0]  configuration_axis;
    logic        configuration_send;
    logic        dac_ready;

    modport master (
        output M_AXISCFG_tdata,
        output M_AXISCFG_tvalid,
        output configuration_mode,
        output configuration_axis,
        output configuration_send,
        input  dac_ready
    );

    modport slave (
        input  M_AXISCFG_tdata,
        input  M_AXISCFG_tvalid,
        input  configuration_mode,
        input  configuration_axis,
        input  configuration_send,
        output dac_ready
    );
endinterface

// File: rtl/axis_ad5791_cfg_seq.sv
// Runs the AD5791 register program (control word, then midscale on every axis) through
// the DAC driver's configuration port, then returns the driver to streaming mode.
module axis_ad5791_cfg_seq #(
    parameter int          NUM_DAC   = 6,
    parameter logic [23:0] CTRL_WORD = 24'h200002,
    parameter logic [23:0] DAC_WORD  = 24'h100000,
    parameter int          HOLD      = 2,
    parameter int          GAP       = 16,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic                         start,
    axis_ad5791_cfg_seq_if.master        cfg,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   skipped,
    output logic [3:0]                   state_dbg
);
    typedef enum logic [3:0] {
        S_IDLE, S_ENTER, S_LOAD, S_SETTLE, S_SEND, S_DRAIN, S_GAPW, S_NEXT, S_RELEASE
    } state_t;

    // Shared down-counter reload values; each phase ends when the counter reads 0.
    localparam logic [15:0] HOLD_LD   = 16'(HOLD - 1);
    localparam logic [15:0] GAP_LD    = 16'(GAP - 1);
    localparam logic [15:0] TO_LD     = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_AXIS = 3'(NUM_DAC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        step_q, step_d;
    logic [2:0]  axis_q, axis_d;
    logic [23:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        mode_q, mode_d;
    logic        send_q, send_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  skipped_q, skipped_d;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            axis_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            mode_q    <= 1'b0;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            skipped_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            axis_q    <= axis_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            mode_q    <= mode_d;
            send_q    <= send_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            skipped_q <= skipped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        axis_d    = axis_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        mode_d    = mode_q;
        send_d    = send_q;
        busy_d    = busy_q;
        done_d    = done_q;
        skipped_d = skipped_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ENTER;
                    cnt_d     = GAP_LD;
                    step_d    = 1'b0;
                    axis_d    = '0;
                    busy_d    = 1'b1;
                    mode_d    = 1'b1;
                    done_d    = 1'b0;
                    skipped_d = '0;
                end
            end
            S_ENTER: begin
                if (cnt_q == '0) begin
                    state_d  = S_LOAD;
                    cnt_d    = HOLD_LD;
                    axis_d   = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = CTRL_WORD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_LOAD: begin
                // Each axis: HOLD valid cycles, then one idle cycle before the next axis.
                if (tvalid_q) begin
                    if (cnt_q == '0) tvalid_d = 1'b0;
                    else             cnt_d    = cnt_q - 16'd1;
                end else if (axis_q == LAST_AXIS) begin
                    state_d = S_SETTLE;
                    cnt_d   = GAP_LD;
                end else begin
                    axis_d   = axis_q + 3'd1;
                    tvalid_d = 1'b1;
                    cnt_d    = HOLD_LD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SEND;
                    send_d  = 1'b1;
                    cnt_d   = TO_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SEND: begin
                if (!cfg.dac_ready) begin
                    state_d = S_DRAIN;
                    send_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d           = S_GAPW;
                    send_d            = 1'b0;
                    skipped_d[step_q] = 1'b1;
                    cnt_d             = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DRAIN: begin
                if (cfg.dac_ready) begin
                    state_d = S_GAPW;
                    cnt_d   = GAP_LD;
                end
            end
            S_GAPW: begin
                if (cnt_q == '0) state_d = S_NEXT;
                else             cnt_d   = cnt_q - 16'd1;
            end
            S_NEXT: begin
                if (!step_q) begin
                    state_d  = S_LOAD;
                    step_d   = 1'b1;
                    axis_d   = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = DAC_WORD;
                    cnt_d    = HOLD_LD;
                end else begin
                    state_d = S_RELEASE;
                    mode_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign cfg.M_AXISCFG_tdata    = {8'h00, tdata_q};
    assign cfg.M_AXISCFG_tvalid   = tvalid_q;
    assign cfg.configuration_mode = mode_q;
    assign cfg.configuration_axis = axis_q;
    assign cfg.configuration_send = send_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign skipped   = skipped_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_axis_ad5791_cfg_seq.sv
// Bench for the AD5791 configuration sequencer: a DAC-driver model answers send requests,
// a monitor records CFG beats and send pulses, and each program is scored against the register program.
module tb_axis_ad5791_cfg_seq;
  localparam int          NUM_DAC   = 6;
  localparam int          HOLD      = 2;
  localparam int          GAP       = 16;
  localparam int          TIMEOUT   = 1024;
  localparam logic [23:0] CTRL_WORD = 24'h200002;
  localparam logic [23:0] DAC_WORD  = 24'h100000;
  localparam int          W         = 35;

  // clock / reset
  logic a_clk = 1'b0;
  logic a_resetn = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [1:0] skipped;
  logic [3:0] state_dbg;

  always #4 a_clk = ~a_clk;

  axis_ad5791_cfg_seq_if bus();

  axis_ad5791_cfg_seq #(
    .NUM_DAC(NUM_DAC), .CTRL_WORD(CTRL_WORD), .DAC_WORD(DAC_WORD),
    .HOLD(HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .start(start), .cfg(bus),
    .busy(busy), .done(done), .skipped(skipped), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // driver model: answers send s after drv_delay cycles if drv_mask[s], then stays busy drv_low cycles
  int drv_delay = 3;
  int drv_low = 260;
  logic [1:0] drv_mask = 2'b11;
  int sends_seen = 0;
  int dly = 0;
  int low_cnt = 0;
  logic pend = 1'b0;
  logic send_prev = 1'b0;

  initial begin
    bus.dac_ready = 1'b1;
    forever begin
      @(negedge a_clk);
      if (!a_resetn) begin
        pend = 1'b0; low_cnt = 0; send_prev = 1'b0; bus.dac_ready = 1'b1;
      end else begin
        if (pend) begin
          if (dly == 0) begin bus.dac_ready = 1'b0; low_cnt = drv_low; pend = 1'b0; end
          else dly--;
        end else if (low_cnt > 0) begin
          low_cnt--;
          if (low_cnt == 0) bus.dac_ready = 1'b1;
        end
        if (bus.configuration_send && !send_prev) begin
          if (sends_seen > 1 || drv_mask[sends_seen]) begin pend = 1'b1; dly = drv_delay - 1; end
          sends_seen++;
        end
        send_prev = bus.configuration_send;
      end
    end
  end

  // monitor
  logic [W-1:0] obs_q[$];
  int run_q[$];
  int send_q[$];
  int vrun = 0, srun = 0, mode_bad = 0;

  initial begin
    forever begin
      @(negedge a_clk);
      if (bus.M_AXISCFG_tvalid) begin
        obs_q.push_back({bus.M_AXISCFG_tdata, bus.configuration_axis});
        vrun++;
      end else if (vrun > 0) begin
        run_q.push_back(vrun);
        vrun = 0;
      end
      if (bus.configuration_send) srun++;
      else if (srun > 0) begin send_q.push_back(srun); srun = 0; end
      if ((bus.M_AXISCFG_tvalid || bus.configuration_send) && !bus.configuration_mode) mode_bad++;
    end
  end

  task automatic clr_mon();
    obs_q.delete(); run_q.delete(); send_q.delete();
    vrun = 0; srun = 0; mode_bad = 0; sends_seen = 0;
  endtask

  // driver tasks
  task automatic drv_set(input int d, input int l, input logic [1:0] m);
    drv_delay = d; drv_low = l; drv_mask = m;
  endtask

  task automatic launch(input string tag);
    clr_mon();
    @(negedge a_clk); start = 1'b1;
    @(negedge a_clk); start = 1'b0;
    check({tag, ":busy+1"}, busy, 1);
    check({tag, ":mode+1"}, bus.configuration_mode, 1);
    check({tag, ":done_clr"}, done, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 6000) begin @(negedge a_clk); n++; end
    check({tag, ":finish_in_budget"}, (n < 6000), 1);
  endtask

  // scoreboard: the program is CTRL_WORD then DAC_WORD, each on axes 0..NUM_DAC-1, HOLD beats each
  task automatic verify(input string tag, input int d, input logic [1:0] m, input logic [1:0] exp_sk);
    logic [W-1:0] exp_q[$];
    check({tag, ":done"}, done, 1);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":mode"}, bus.configuration_mode, 0);
    check({tag, ":skipped"}, skipped, exp_sk);
    check({tag, ":mode_cover"}, mode_bad, 0);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < NUM_DAC; a++)
        for (int h = 0; h < HOLD; h++)
          exp_q.push_back({8'h00, (s == 0) ? CTRL_WORD : DAC_WORD, 3'(a)});
    check({tag, ":beats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s:beat%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, ":runs"}, run_q.size(), 2 * NUM_DAC);
    for (int i = 0; i < run_q.size(); i++)
      check($sformatf("%s:run%0d", tag, i), run_q[i], HOLD);
    check({tag, ":sends"}, send_q.size(), 2);
    for (int s = 0; s < send_q.size() && s < 2; s++)
      check($sformatf("%s:send%0d_len", tag, s), send_q[s], m[s] ? d + 1 : TIMEOUT);
  endtask

  task automatic run_prog(input string tag, input int d, input int l, input logic [1:0] m,
                          input logic [1:0] exp_sk);
    drv_set(d, l, m);
    launch(tag);
    wait_done(tag);
    verify(tag, d, m, exp_sk);
  endtask

  typedef struct {
    string      name;
    int         delay;
    int         low;
    logic [1:0] mask;
    logic [1:0] exp_skipped;
  } vec_t;

  vec_t vecs[5];

  initial begin
    repeat (90000) @(posedge a_clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"nominal",  3, 260, 2'b11, 2'b00};
    vecs[1] = '{"instant",  1,   1, 2'b11, 2'b00};
    vecs[2] = '{"tied_hi",  1,   1, 2'b00, 2'b11};
    vecs[3] = '{"to_step0", 2,  40, 2'b10, 2'b01};
    vecs[4] = '{"to_step1", 5,  10, 2'b01, 2'b10};

    // reset state
    repeat (3) @(negedge a_clk);
    check("rst:tdata", bus.M_AXISCFG_tdata, 0);
    check("rst:tvalid", bus.M_AXISCFG_tvalid, 0);
    check("rst:mode", bus.configuration_mode, 0);
    check("rst:axis", bus.configuration_axis, 0);
    check("rst:send", bus.configuration_send, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:skipped", skipped, 0);
    a_resetn = 1'b1;
    repeat (2) @(negedge a_clk);

    for (int v = 0; v < 5; v++)
      run_prog(vecs[v].name, vecs[v].delay, vecs[v].low, vecs[v].mask, vecs[v].exp_skipped);

    // start during DRAIN is ignored; program completes once
    begin
      int n = 0;
      drv_set(3, 260, 2'b11);
      launch("drain");
      while (send_q.size() == 0 && n < 3000) begin @(negedge a_clk); n++; end
      check("drain:reached", send_q.size(), 1);
      start = 1'b1; @(negedge a_clk); start = 1'b0;
      check("drain:busy_kept", busy, 1);
      wait_done("drain");
      verify("drain", 3, 2'b11, 2'b00);
    end

    // randomized driver behaviour; reference: skipped bit s set exactly when send s is ignored
    for (int r = 0; r < 4; r++) begin
      int d, l;
      logic [1:0] m;
      d = $urandom_range(1, 20);
      l = $urandom_range(1, 300);
      m = 2'($urandom_range(0, 3));
      run_prog($sformatf("rand%0d", r), d, l, m, ~m);
    end

    // reset during step-1 SEND, then a clean rerun from step 0
    begin
      int n = 0;
      drv_set(1, 1, 2'b00);
      launch("rst_send");
      while (!(send_q.size() == 1 && srun > 50) && n < 4000) begin @(negedge a_clk); n++; end
      check("rst_send:reached", (n < 4000), 1);
      #1 a_resetn = 1'b0;
      #1;
      check("rst_send:tdata", bus.M_AXISCFG_tdata, 0);
      check("rst_send:tvalid", bus.M_AXISCFG_tvalid, 0);
      check("rst_send:mode", bus.configuration_mode, 0);
      check("rst_send:axis", bus.configuration_axis, 0);
      check("rst_send:send", bus.configuration_send, 0);
      check("rst_send:busy", busy, 0);
      check("rst_send:done", done, 0);
      check("rst_send:skipped", skipped, 0);
      @(negedge a_clk);
      a_resetn = 1'b1;
      repeat (2) @(negedge a_clk);
      run_prog("post_rst", 2, 5, 2'b11, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
